// File: rtl/eeprom_tx_sched.sv
// Page-write scheduler: drains the tx FIFO into SPI EEPROM WREN/WRITE/RDSR command sequences, splitting at page boundaries.
// Optional macro EEPROM_POLL_TIMEOUT_EN adds a per-page RDSR poll limit (POLL_MAX) that aborts with an ERR pulse.
module eeprom_tx_sched #(
  parameter int PAGE_SIZE = 64,
  parameter int CS_GAP    = 4,
  parameter int POLL_MAX  = 65535
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] START_ADDR,
  input  logic [12:0] BYTE_CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  input  logic        FIFO_EMPTY,
  input  logic [7:0]  FIFO_Q,
  output logic        FIFO_RE,
  output logic [7:0]  SPI_TXD,
  output logic        SPI_TXV,
  input  logic        SPI_TXRDY,
  input  logic [7:0]  SPI_RXD,
  input  logic        SPI_RXV,
  output logic        SPI_CS_N
);

  localparam int PW = $clog2(PAGE_SIZE);

  if (PAGE_SIZE < 8 || PAGE_SIZE > 256 || (PAGE_SIZE & (PAGE_SIZE - 1)) != 0 ||
      CS_GAP < 1 || POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_param
    $error("eeprom_tx_sched: illegal parameter value");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_GAP, S_WR_CMD, S_WR_AH, S_WR_AL, S_WR_DATA, S_POLL_CMD, S_POLL_DUM
  } state_t;

  state_t      state;
  state_t      gap_next;
  logic        send;        // a byte is (or will be, once the FIFO has data) offered
  logic [7:0]  cmd_byte;
  logic [15:0] addr;
  logic [12:0] remaining;
  logic [8:0]  page_left;
  logic [15:0] gap_cnt;
  logic        busy_q;
  logic        done_q;
  logic        cs_n_q;
  logic [8:0]  room;
  logic [8:0]  page_len;
  logic        accept;
  logic        rx;
  logic        unused_rxd;

`ifdef EEPROM_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt;
  logic        err_q;
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign room     = 9'(PAGE_SIZE) - 9'(addr[PW-1:0]);
  assign page_len = (remaining < 13'(room)) ? remaining[8:0] : room;

  assign SPI_TXV  = send && (state != S_WR_DATA || !FIFO_EMPTY);
  assign SPI_TXD  = (state == S_WR_DATA) ? FIFO_Q : cmd_byte;
  assign accept   = SPI_TXV && SPI_TXRDY;
  // The response to an offered byte can only arrive once it has been accepted.
  assign rx       = SPI_RXV && !send;
  assign FIFO_RE  = accept && (state == S_WR_DATA);

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SPI_CS_N = cs_n_q;
  assign unused_rxd = &{1'b0, SPI_RXD[7:1]};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      gap_next  <= S_IDLE;
      send      <= 1'b0;
      cmd_byte  <= 8'h00;
      addr      <= 16'h0000;
      remaining <= 13'd0;
      page_left <= 9'd0;
      gap_cnt   <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
`ifdef EEPROM_POLL_TIMEOUT_EN
      poll_cnt  <= 16'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef EEPROM_POLL_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      if (accept) send <= 1'b0;

      case (state)
        S_IDLE: begin
          if (START) begin
            if (BYTE_CNT == 13'd0) begin
              done_q <= 1'b1;
            end else begin
              addr      <= START_ADDR;
              remaining <= BYTE_CNT;
              busy_q    <= 1'b1;
              cs_n_q    <= 1'b0;
              send      <= 1'b1;
              cmd_byte  <= 8'h06;
              state     <= S_WREN;
            end
          end
        end
        S_WREN: begin
          if (rx) begin
            state    <= S_GAP;
            gap_next <= S_WR_CMD;
            cs_n_q   <= 1'b1;
            gap_cnt  <= 16'(CS_GAP - 1);
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) begin
            state  <= gap_next;
            cs_n_q <= 1'b0;
            send   <= 1'b1;
            case (gap_next)
              S_WR_CMD:   cmd_byte <= 8'h02;
              S_POLL_CMD: cmd_byte <= 8'h05;
              default:    cmd_byte <= 8'h06;
            endcase
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        S_WR_CMD: begin
          if (rx) begin
            state    <= S_WR_AH;
            cmd_byte <= addr[15:8];
            send     <= 1'b1;
          end
        end
        S_WR_AH: begin
          if (rx) begin
            state    <= S_WR_AL;
            cmd_byte <= addr[7:0];
            send     <= 1'b1;
          end
        end
        S_WR_AL: begin
          if (rx) begin
            state     <= S_WR_DATA;
            page_left <= page_len;
            send      <= 1'b1;
          end
        end
        S_WR_DATA: begin
          if (accept) begin
            addr      <= addr + 16'd1;
            remaining <= remaining - 13'd1;
            page_left <= page_left - 9'd1;
          end
          if (rx) begin
            if (page_left == 9'd0) begin
              state    <= S_GAP;
              gap_next <= S_POLL_CMD;
              cs_n_q   <= 1'b1;
              gap_cnt  <= 16'(CS_GAP - 1);
`ifdef EEPROM_POLL_TIMEOUT_EN
              poll_cnt <= 16'd0;
`endif
            end else begin
              send <= 1'b1;
            end
          end
        end
        S_POLL_CMD: begin
          if (rx) begin
            state    <= S_POLL_DUM;
            cmd_byte <= 8'h00;
            send     <= 1'b1;
          end
        end
        S_POLL_DUM: begin
          if (rx) begin
            if (!SPI_RXD[0]) begin
              if (remaining == 13'd0) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                cs_n_q <= 1'b1;
              end else begin
                state    <= S_GAP;
                gap_next <= S_WREN;
                cs_n_q   <= 1'b1;
                gap_cnt  <= 16'(CS_GAP - 1);
              end
            end else begin
`ifdef EEPROM_POLL_TIMEOUT_EN
              if (poll_cnt == 16'(POLL_MAX - 1)) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
                cs_n_q <= 1'b1;
              end else begin
                poll_cnt <= poll_cnt + 16'd1;
                state    <= S_GAP;
                gap_next <= S_POLL_CMD;
                cs_n_q   <= 1'b1;
                gap_cnt  <= 16'(CS_GAP - 1);
              end
`else
              state    <= S_GAP;
              gap_next <= S_POLL_CMD;
              cs_n_q   <= 1'b1;
              gap_cnt  <= 16'(CS_GAP - 1);
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_tx_sched.sv
// Bench for eeprom_tx_sched: FIFO and SPI engine models drive the DUT; a monitor scores the observed byte/DONE/ERR stream.
module tb_eeprom_tx_sched;

  localparam int CS_GAP = 4;
`ifdef EEPROM_POLL_TIMEOUT_EN
  localparam int PMAX = 3;
`else
  localparam int PMAX = 65535;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [15:0] START_ADDR;
  logic [12:0] BYTE_CNT;
  logic        BUSY, DONE, ERR;
  logic        FIFO_EMPTY;
  logic [7:0]  FIFO_Q;
  logic        FIFO_RE;
  logic [7:0]  SPI_TXD;
  logic        SPI_TXV;
  logic        SPI_TXRDY;
  logic [7:0]  SPI_RXD;
  logic        SPI_RXV;
  logic        SPI_CS_N;

  eeprom_tx_sched #(.PAGE_SIZE(64), .CS_GAP(CS_GAP), .POLL_MAX(PMAX)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR), .BYTE_CNT(BYTE_CNT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_Q(FIFO_Q), .FIFO_RE(FIFO_RE),
    .SPI_TXD(SPI_TXD), .SPI_TXV(SPI_TXV), .SPI_TXRDY(SPI_TXRDY),
    .SPI_RXD(SPI_RXD), .SPI_RXV(SPI_RXV), .SPI_CS_N(SPI_CS_N)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];   // 0x0xx = SPI byte, 0x100 = DONE, 0x200 = ERR
  logic [7:0] fq[$];      // FIFO contents
  logic [7:0] sq[$];      // RDSR status responses
  bit         mon_en = 1'b1;
  int         re_cnt = 0;
  int         pops   = 0;
  int         stall_at = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d0, input int n);
    exp_q.push_back(10'h006);
    exp_q.push_back(10'h002);
    exp_q.push_back({2'b00, a[15:8]});
    exp_q.push_back({2'b00, a[7:0]});
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, 8'(d0 + i)});
  endtask

  task automatic exp_poll(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(10'h005);
      exp_q.push_back(10'h000);
    end
  endtask

  task automatic fill(input logic [7:0] d0, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(d0 + i));
  endtask

  // FIFO and SPI shift-engine model: inputs change on the falling edge, outcomes sampled 4ns later.
  initial begin
    int         cyc = 0;
    bit         rx_pend = 0;
    int         rx_dly = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] cur_cmd = 8'h00;
    int         idx = 0;
    bit         new_cmd = 1;
    int         stall_cnt = 0;
    bit         stalled;
    SPI_TXRDY = 1'b0; SPI_RXV = 1'b0; SPI_RXD = 8'h00; FIFO_EMPTY = 1'b1; FIFO_Q = 8'h00;
    forever begin
      @(negedge CLK);
      cyc++;
      SPI_RXV = 1'b0;
      if (rx_pend) begin
        if (rx_dly == 0) begin
          SPI_RXV = 1'b1; SPI_RXD = rx_byte; rx_pend = 0;
        end else rx_dly--;
      end
      SPI_TXRDY  = (cyc % 3) != 0;
      stalled    = stall_cnt > 0;
      if (stall_cnt > 0) stall_cnt--;
      FIFO_EMPTY = (fq.size() == 0) || stalled;
      FIFO_Q     = (fq.size() != 0) ? fq[0] : 8'h00;
      #4;
      if (!RESET) begin
        rx_pend = 0; new_cmd = 1; stall_cnt = 0;
        continue;
      end
      if (SPI_CS_N) new_cmd = 1;
      if (stalled) begin
        chk("stall_txv", SPI_TXV, 0);
        chk("stall_csn", SPI_CS_N, 0);
      end
      if (SPI_TXV && SPI_TXRDY) begin
        if (new_cmd) begin cur_cmd = SPI_TXD; idx = 0; new_cmd = 0; end
        else idx++;
        rx_byte = 8'hFF;
        if (cur_cmd == 8'h05 && idx == 1) rx_byte = (sq.size() != 0) ? sq.pop_front() : 8'h00;
        rx_pend = 1; rx_dly = 1;
        if (FIFO_RE) begin
          void'(fq.pop_front());
          pops++;
          if (stall_at != 0 && pops == stall_at) stall_cnt = 20;
        end
      end
    end
  end

  // Monitor: scores every accepted byte and DONE/ERR pulse against the expected stream, plus CS gap length.
  task automatic check_ev(input logic [9:0] obs);
    logic [9:0] e;
    if (!mon_en) return;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", obs, 10'h3FF);
    end else begin
      e = exp_q.pop_front();
      chk("stream", obs, e);
    end
  endtask

  initial begin
    bit prev_cs = 1;
    bit in_gap  = 0;
    int gap_run = 0;
    forever begin
      @(negedge CLK);
      #4;
      if (!RESET) begin in_gap = 0; prev_cs = 1; continue; end
      if (SPI_TXV && SPI_TXRDY) check_ev({2'b00, SPI_TXD});
      if (DONE) check_ev(10'h100);
      if (ERR)  check_ev(10'h200);
      if (FIFO_RE) re_cnt++;
      if (!BUSY) in_gap = 0;
      else if (SPI_CS_N) begin
        if (!prev_cs) begin in_gap = 1; gap_run = 0; end
        if (in_gap) gap_run++;
      end else if (prev_cs && in_gap) begin
        chk("cs_gap", gap_run, CS_GAP);
        in_gap = 0;
      end
      prev_cs = SPI_CS_N;
    end
  end

  task automatic run(input string nm, input logic [15:0] a, input logic [12:0] n, input int exp_re);
    int k;
    re_cnt = 0;
    pops   = 0;
    @(negedge CLK);
    START = 1'b1; START_ADDR = a; BYTE_CNT = n;
    @(negedge CLK);
    START = 1'b0;
    #4;
    if (n == 13'd0) begin
      chk({nm, "_done_next"}, DONE, 1);
      chk({nm, "_busy"}, BUSY, 0);
    end else begin
      chk({nm, "_busy"}, BUSY, 1);
    end
    for (k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      chk({nm, "_timeout_left"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge CLK);
    #4;
    chk({nm, "_busy_end"}, BUSY, 0);
    chk({nm, "_fifo_re"}, re_cnt, exp_re);
    chk({nm, "_fifo_left"}, fq.size(), 0);
    sq.delete();
  endtask

  initial begin
    RESET = 1'b0; START = 1'b0; START_ADDR = 16'h0000; BYTE_CNT = 13'd0;
    repeat (3) @(negedge CLK);
    #4;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_fifo_re", FIFO_RE, 0);
    chk("rst_txv", SPI_TXV, 0);
    chk("rst_txd", SPI_TXD, 8'h00);
    chk("rst_csn", SPI_CS_N, 1);
    @(negedge CLK);
    RESET = 1'b1;

    // single page
    fill(8'hA0, 4); sq.push_back(8'h00);
    exp_write(16'h0010, 8'hA0, 4); exp_poll(1); exp_q.push_back(10'h100);
    run("basic", 16'h0010, 13'd4, 4);

    // page split at 0x0040
    fill(8'hB0, 4); sq.push_back(8'h00); sq.push_back(8'h00);
    exp_write(16'h003E, 8'hB0, 2); exp_poll(1);
    exp_write(16'h0040, 8'hB2, 2); exp_poll(1); exp_q.push_back(10'h100);
    run("split", 16'h003E, 13'd4, 4);

    // WIP busy three times
    fill(8'hC0, 1);
    sq.push_back(8'h01); sq.push_back(8'h01); sq.push_back(8'h01); sq.push_back(8'h00);
    exp_write(16'h0100, 8'hC0, 1); exp_poll(4); exp_q.push_back(10'h100);
    run("wip", 16'h0100, 13'd1, 1);

    // address wrap
    fill(8'hD0, 2); sq.push_back(8'h00); sq.push_back(8'h00);
    exp_write(16'hFFFF, 8'hD0, 1); exp_poll(1);
    exp_write(16'h0000, 8'hD1, 1); exp_poll(1); exp_q.push_back(10'h100);
    run("wrap", 16'hFFFF, 13'd2, 2);

    // FIFO runs dry for 20 cycles after two bytes
    stall_at = 2;
    fill(8'hE0, 4); sq.push_back(8'h00);
    exp_write(16'h0020, 8'hE0, 4); exp_poll(1); exp_q.push_back(10'h100);
    run("stall", 16'h0020, 13'd4, 4);
    stall_at = 0;

    // zero-length request
    exp_q.push_back(10'h100);
    run("zero", 16'h1234, 13'd0, 0);

`ifdef EEPROM_POLL_TIMEOUT_EN
    fill(8'h77, 1);
    for (int i = 0; i < 5; i++) sq.push_back(8'h01);
    exp_write(16'h0200, 8'h77, 1); exp_poll(3); exp_q.push_back(10'h200);
    run("timeout", 16'h0200, 13'd1, 1);
`endif

    // reset in the middle of the data phase
    mon_en = 1'b0;
    pops = 0;
    fill(8'hF0, 8);
    @(negedge CLK);
    START = 1'b1; START_ADDR = 16'h0000; BYTE_CNT = 13'd8;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k < 500 && pops < 2; k++) @(negedge CLK);
    chk("midrst_reached_data", (pops >= 2), 1);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("midrst_csn", SPI_CS_N, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_txv", SPI_TXV, 0);
    @(negedge CLK);
    fq.delete(); sq.delete(); exp_q.delete();
    @(negedge CLK);
    RESET = 1'b1;
    #4;
    chk("postrst_busy", BUSY, 0);
    chk("postrst_txd", SPI_TXD, 8'h00);
    chk("postrst_csn", SPI_CS_N, 1);
    mon_en = 1'b1;

    // scheduler recovers after reset
    fill(8'h40, 3); sq.push_back(8'h00);
    exp_write(16'h0080, 8'h40, 3); exp_poll(1); exp_q.push_back(10'h100);
    run("after_rst", 16'h0080, 13'd3, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
